chan_sel_mux: RTL and testbench
===============================

// Module: chan_sel_mux
//
// PURPOSE
//   Parametrised N-channel, WIDTH-bit registered data selector with a handshaked
//   select port and a programmable guard gap on channel switch.
//   Used wherever several sources share one sink and a switch must never emit
//   a mixed or stale word. Successor to the 2:1 combinational data mux.
//
// PARAMETERS
//   WIDTH      8               data width per channel (>=1)
//   N_CH       4               number of input channels (>=2)
//   GUARD_CYC  2               output-blanking cycles on a switch (0..255)
//   SEL_W      $clog2(N_CH)    select width (derived, do not override)
//
// PORTS
//   clk        in   1             rising-edge clock
//   rst_n      in   1             asynchronous active-low reset
//   din        in   N_CH*WIDTH    channel data, ch k = din[k*WIDTH +: WIDTH]
//   din_valid  in   N_CH          per-channel data valid
//   sel_req    in   SEL_W         requested channel
//   sel_valid  in   1             select request valid
//   sel_ready  out  1             select request can be accepted
//   dout       out  WIDTH         registered selected data
//   dout_valid out  1             registered selected valid
//   cur_sel    out  SEL_W         currently selected (or target) channel
//   sel_err    out  1             1-cycle pulse: out-of-range request rejected
//
// BEHAVIOUR
//   - Reset (async assert, sync-safe deassert): state=ACTIVE, cur_sel=0,
//     dout=0, dout_valid=0, sel_ready=1, sel_err=0, guard counter=0.
//   - Request accepted on a rising edge with sel_valid & sel_ready.
//   - sel_ready = (state==ACTIVE); combinational from state only.
//   - ACTIVE: each edge dout<=din[cur_sel], dout_valid<=din_valid[cur_sel]
//     (latency 1 cycle). Data word passes unmodified.
//   - Accepted request, sel_req>=N_CH: sel_err=1 for one cycle, cur_sel and
//     data path unchanged, no gap.
//   - Accepted request, sel_req==cur_sel: no-op, no gap, no sel_err.
//   - Accepted request, new valid channel, GUARD_CYC=0: cur_sel<=sel_req and
//     dout<=din[sel_req] on the accept edge; no gap.
//   - Accepted request, new valid channel, GUARD_CYC>0: on the accept edge
//     cur_sel<=sel_req, dout<=0, dout_valid<=0, cnt<=GUARD_CYC-1, state=GUARD.
//   - GUARD: dout=0, dout_valid=0 held; cnt!=0 -> cnt--; cnt==0 -> state=ACTIVE
//     and dout<=din[cur_sel], dout_valid<=din_valid[cur_sel] on that edge.
//     dout_valid is low for exactly GUARD_CYC cycles.
//   - sel_valid while sel_ready=0 is ignored (requester must hold it).
//   - Reset mid-GUARD aborts the switch: back to ACTIVE on channel 0.
//   - sel_err and dout_valid never both change due to the same rejected request.
//
// TESTING
//   1. Reset: rst_n=0 mid-cycle -> all outputs 0, sel_ready=1 immediately.
//   2. Pass-through: cur_sel=0, din ch0=8'hA5 valid -> dout=8'hA5, valid=1 next cycle.
//   3. Switch 0->2, GUARD_CYC=2: dout_valid low exactly 2 cycles, sel_ready low
//      2 cycles, then dout=ch2 data; cur_sel=2 from accept edge.
//   4. sel_req=5 with N_CH=4 -> sel_err one-cycle pulse, cur_sel unchanged, no gap.
//   5. Same-channel request and GUARD_CYC=0 build: switch 1->3 -> no invalid cycle.
//   6. rst_n asserted during GUARD -> cur_sel=0, state ACTIVE, sel_ready=1.

Source files
------------

// File: rtl/chan_sel_mux.sv
// chan_sel_mux: N-channel registered data selector with a handshaked select
// port. A switch to a new channel blanks the output for GUARD_CYC cycles.
module chan_sel_mux #(
    parameter int WIDTH     = 8,
    parameter int N_CH      = 4,
    parameter int GUARD_CYC = 2,
    localparam int SEL_W    = $clog2(N_CH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [N_CH*WIDTH-1:0] din,
    input  logic [N_CH-1:0]       din_valid,
    input  logic [SEL_W-1:0]      sel_req,
    input  logic                  sel_valid,
    output logic                  sel_ready,
    output logic [WIDTH-1:0]      dout,
    output logic                  dout_valid,
    output logic [SEL_W-1:0]      cur_sel,
    output logic                  sel_err
);
    // Select handshake: a request transfers on a rising edge where sel_valid and
    // sel_ready are both high; the requester holds sel_req stable until then.

    localparam int N_SLOT = 1 << SEL_W;
    localparam logic [7:0] GUARD_INIT = (GUARD_CYC > 0) ? 8'(GUARD_CYC - 1) : 8'd0;

    typedef enum logic {ACTIVE = 1'b0, GUARD = 1'b1} state_t;

    state_t            state;
    logic [7:0]        cnt;
    logic [WIDTH-1:0]  ch_data [N_SLOT];
    logic [N_SLOT-1:0] ch_valid;
    logic              accept;
    logic              req_oor;
    logic              req_new;

    // Pad unused select codes so any SEL_W-bit index is safe.
    for (genvar k = 0; k < N_SLOT; k++) begin : g_slot
        if (k < N_CH) begin : g_used
            assign ch_data[k]  = din[k*WIDTH +: WIDTH];
            assign ch_valid[k] = din_valid[k];
        end else begin : g_pad
            assign ch_data[k]  = '0;
            assign ch_valid[k] = 1'b0;
        end
    end

    assign sel_ready = (state == ACTIVE);
    assign accept    = sel_valid && sel_ready;
    assign req_oor   = (32'(sel_req) >= N_CH);
    assign req_new   = !req_oor && (sel_req != cur_sel);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ACTIVE;
            cur_sel    <= '0;
            dout       <= '0;
            dout_valid <= 1'b0;
            sel_err    <= 1'b0;
            cnt        <= '0;
        end else begin
            sel_err <= 1'b0;
            case (state)
                ACTIVE: begin
                    if (accept && req_new) begin
                        cur_sel <= sel_req;
                        if (GUARD_CYC == 0) begin
                            dout       <= ch_data[sel_req];
                            dout_valid <= ch_valid[sel_req];
                        end else begin
                            dout       <= '0;
                            dout_valid <= 1'b0;
                            cnt        <= GUARD_INIT;
                            state      <= GUARD;
                        end
                    end else begin
                        // Rejected and same-channel requests leave the data path untouched.
                        sel_err    <= accept && req_oor;
                        dout       <= ch_data[cur_sel];
                        dout_valid <= ch_valid[cur_sel];
                    end
                end
                GUARD: begin
                    if (cnt != 8'd0) begin
                        cnt        <= cnt - 8'd1;
                        dout       <= '0;
                        dout_valid <= 1'b0;
                    end else begin
                        state      <= ACTIVE;
                        dout       <= ch_data[cur_sel];
                        dout_valid <= ch_valid[cur_sel];
                    end
                end
                default: begin
                    state      <= ACTIVE;
                    dout       <= '0;
                    dout_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_chan_sel_mux.sv
// Bench for chan_sel_mux: a 4-channel GUARD_CYC=2 instance and a 5-channel
// GUARD_CYC=0 instance driven side by side against an output-stream model.
module tb_chan_sel_mux;
    localparam int W   = 8;
    localparam int NA  = 4;
    localparam int GA  = 2;
    localparam int SWA = 2;
    localparam int NB  = 5;
    localparam int GB  = 0;
    localparam int SWB = 3;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [NA*W-1:0] din_a = '0;
    logic [NA-1:0]   dv_a  = '0;
    logic [SWA-1:0]  req_a = '0;
    logic            sv_a  = 1'b0;
    logic            a_ready, a_dv, a_err;
    logic [W-1:0]    a_dout;
    logic [SWA-1:0]  a_cur;

    logic [NB*W-1:0] din_b = '0;
    logic [NB-1:0]   dv_b  = '0;
    logic [SWB-1:0]  req_b = '0;
    logic            sv_b  = 1'b0;
    logic            b_ready, b_dv, b_err;
    logic [W-1:0]    b_dout;
    logic [SWB-1:0]  b_cur;

    chan_sel_mux #(.WIDTH(W), .N_CH(NA), .GUARD_CYC(GA)) dut_a (
        .clk(clk), .rst_n(rst_n), .din(din_a), .din_valid(dv_a),
        .sel_req(req_a), .sel_valid(sv_a), .sel_ready(a_ready),
        .dout(a_dout), .dout_valid(a_dv), .cur_sel(a_cur), .sel_err(a_err)
    );

    chan_sel_mux #(.WIDTH(W), .N_CH(NB), .GUARD_CYC(GB)) dut_b (
        .clk(clk), .rst_n(rst_n), .din(din_b), .din_valid(dv_b),
        .sel_req(req_b), .sel_valid(sv_b), .sel_ready(b_ready),
        .dout(b_dout), .dout_valid(b_dv), .cur_sel(b_cur), .sel_err(b_err)
    );

    // ---------------- scoreboard ----------------
    // Observation word: {sel_ready, sel_err, cur_sel[2:0], dout_valid, dout[7:0]}
    logic [13:0] exp_a_q[$];
    logic [13:0] exp_b_q[$];
    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [13:0] act, input logic [13:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // Per instance: selected channel, number of blanked outputs still owed,
    // and whether the last observed output accepted requests.
    int m_sel[2];
    int m_bl[2];
    bit m_rdy[2];

    function automatic logic [13:0] model_step(input int id, input int n, input int g,
                                               input logic [8*W-1:0] d, input logic [7:0] v,
                                               input int req, input logic svalid, input logic rst_ok);
        logic       err;
        logic       ov;
        logic [7:0] od;
        logic       rdy;
        if (!rst_ok) begin
            m_sel[id] = 0;
            m_bl[id]  = 0;
            m_rdy[id] = 1'b1;
            return {1'b1, 1'b0, 3'd0, 1'b0, 8'd0};
        end
        err = 1'b0;
        if (m_rdy[id] && svalid) begin
            if (req >= n) err = 1'b1;
            else if (req != m_sel[id]) begin
                m_sel[id] = req;
                m_bl[id]  = g;
            end
        end
        if (m_bl[id] > 0) begin
            od = 8'd0;
            ov = 1'b0;
            rdy = 1'b0;
            m_bl[id]--;
        end else begin
            od = d[m_sel[id]*W +: W];
            ov = v[m_sel[id]];
            rdy = 1'b1;
        end
        m_rdy[id] = rdy;
        return {rdy, err, 3'(m_sel[id]), ov, od};
    endfunction

    // ---------------- driver ----------------
    // Called at a falling edge with inputs set: predicts the next rising-edge
    // result for both instances, then waits for the following falling edge.
    task automatic tick();
        logic [8*W-1:0] da, db;
        logic [7:0]     va, vb;
        da = '0; db = '0; va = '0; vb = '0;
        da[NA*W-1:0] = din_a;
        db[NB*W-1:0] = din_b;
        va[NA-1:0]   = dv_a;
        vb[NB-1:0]   = dv_b;
        exp_a_q.push_back(model_step(0, NA, GA, da, va, int'(req_a), sv_a, rst_n));
        exp_b_q.push_back(model_step(1, NB, GB, db, vb, int'(req_b), sv_b, rst_n));
        @(negedge clk);
    endtask

    // ---------------- monitor ----------------
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (exp_a_q.size() > 0)
                check("stream_a", {a_ready, a_err, 1'b0, a_cur, a_dv, a_dout}, exp_a_q.pop_front());
            if (exp_b_q.size() > 0)
                check("stream_b", {b_ready, b_err, b_cur, b_dv, b_dout}, exp_b_q.pop_front());
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        @(negedge clk);
        repeat (3) tick();
        check("reset_ready_a", a_ready, 1);
        check("reset_out_a", {a_err, a_cur, a_dv, a_dout}, 0);
        rst_n = 1'b1;

        // Pass-through on channel 0
        din_a = {8'h11, 8'h3C, 8'h22, 8'hA5};
        dv_a  = 4'b0101;
        tick();
        check("pass_dout", a_dout, 8'hA5);
        check("pass_valid", a_dv, 1);

        // Switch 0 -> 2 with a two-cycle guard
        req_a = 2'd2; sv_a = 1'b1;
        tick();
        sv_a = 1'b0;
        check("switch_cur_sel", a_cur, 2);
        check("switch_blank0", {a_ready, a_dv, a_dout}, 0);
        tick();
        check("switch_blank1", {a_ready, a_dv, a_dout}, 0);
        tick();
        check("switch_data", {a_ready, a_dv, a_dout}, {2'b11, 8'h3C});

        // Out-of-range, same-channel and gapless switches on the GUARD_CYC=0 instance
        din_b = {8'h55, 8'h44, 8'h33, 8'h22, 8'h11};
        dv_b  = 5'b11111;
        tick();
        req_b = 3'd5; sv_b = 1'b1;
        tick();
        check("oor_err", b_err, 1);
        check("oor_keep", {b_cur, b_dv, b_dout}, {3'd0, 1'b1, 8'h11});
        req_b = 3'd0;
        tick();
        check("oor_pulse_end", b_err, 0);
        check("same_ch", {b_cur, b_dv, b_dout}, {3'd0, 1'b1, 8'h11});
        req_b = 3'd1;
        tick();
        check("nogap_to1", {b_cur, b_dv, b_dout}, {3'd1, 1'b1, 8'h22});
        req_b = 3'd3;
        tick();
        check("nogap_to3", {b_err, b_cur, b_dv, b_dout}, {1'b0, 3'd3, 1'b1, 8'h44});
        sv_b = 1'b0;
        tick();

        // Reset asserted mid-guard aborts the switch
        req_a = 2'd1; sv_a = 1'b1;
        tick();
        sv_a = 1'b0;
        check("guard_entered", a_ready, 0);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_a", {a_ready, a_err, a_cur, a_dv, a_dout}, {1'b1, 12'd0});
        check("async_rst_b", {b_ready, b_err, b_cur, b_dv, b_dout}, {1'b1, 13'd0});
        tick();
        rst_n = 1'b1;
        tick();

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            din_a = $urandom();
            dv_a  = 4'($urandom_range(0, 15));
            sv_a  = ($urandom_range(0, 2) == 0);
            req_a = 2'($urandom_range(0, 3));
            din_b = {8'($urandom()), 32'($urandom())};
            dv_b  = 5'($urandom_range(0, 31));
            sv_b  = ($urandom_range(0, 2) == 0);
            req_b = 3'($urandom_range(0, 7));
            rst_n = ($urandom_range(0, 99) != 0);
            tick();
        end
        rst_n = 1'b1; sv_a = 1'b0; sv_b = 1'b0;
        repeat (3) tick();

        check("drain_a", 14'(exp_a_q.size()), 0);
        check("drain_b", 14'(exp_b_q.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
